// File: rtl/insn_sequencer.sv
// Instruction sequencer: fetches one instruction per step from the IP line,
// decodes it, and drives the AP counter, Data counter and I/O handshakes.
module insn_sequencer #(
  parameter int INSN_WIDTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Run,
  input  logic                   Step,
  output logic                   IP_Request,
  input  logic                   IP_Ready,
  input  logic [INSN_WIDTH-1:0]  Insn,
  output logic                   dataIsZeroed,
  output logic                   AP_Request,
  output logic                   AP_Dec,
  input  logic                   AP_Ready,
  output logic                   Data_Request,
  output logic                   Data_Dec,
  output logic                   Data_Set,
  input  logic                   Data_Ready,
  input  logic                   Data_Zero,
  output logic                   Out_Strobe,
  output logic                   In_Request,
  input  logic                   In_Valid,
  output logic [INSN_WIDTH-1:0]  CurInsn,
  output logic                   Busy,
  output logic                   Halted,
  output logic [COUNT_WIDTH-1:0] InsnCount
);

  typedef enum logic [5:0] {
    S_IDLE      = 6'b000001,
    S_FETCH     = 6'b000010,
    S_DECODE    = 6'b000100,
    S_EXEC_WAIT = 6'b001000,
    S_IN_WAIT   = 6'b010000,
    S_HALTED    = 6'b100000
  } state_t;

  localparam logic [INSN_WIDTH-1:0] OP_INC  = INSN_WIDTH'(1);
  localparam logic [INSN_WIDTH-1:0] OP_DEC  = INSN_WIDTH'(2);
  localparam logic [INSN_WIDTH-1:0] OP_RGT  = INSN_WIDTH'(3);
  localparam logic [INSN_WIDTH-1:0] OP_LFT  = INSN_WIDTH'(4);
  localparam logic [INSN_WIDTH-1:0] OP_OUT  = INSN_WIDTH'(7);
  localparam logic [INSN_WIDTH-1:0] OP_IN   = INSN_WIDTH'(8);
  localparam logic [INSN_WIDTH-1:0] OP_HALT = INSN_WIDTH'(15);

  state_t                  state_reg;
  logic                    blank_reg;
  logic [COUNT_WIDTH-1:0]  count_next;
  state_t                  retire_next;

  // Saturating count and post-retire destination, shared by both retire points.
  assign count_next   = (InsnCount == {COUNT_WIDTH{1'b1}}) ? InsnCount : InsnCount + 1'b1;
  assign retire_next  = Run ? S_FETCH : S_IDLE;

  assign dataIsZeroed = Data_Zero;
  assign Busy         = (state_reg != S_IDLE) && (state_reg != S_HALTED);
  assign Halted       = (state_reg == S_HALTED);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= S_IDLE;
      blank_reg    <= 1'b0;
      IP_Request   <= 1'b0;
      AP_Request   <= 1'b0;
      AP_Dec       <= 1'b0;
      Data_Request <= 1'b0;
      Data_Dec     <= 1'b0;
      Data_Set     <= 1'b0;
      Out_Strobe   <= 1'b0;
      In_Request   <= 1'b0;
      CurInsn      <= '0;
      InsnCount    <= '0;
    end else begin
      AP_Request   <= 1'b0;
      Data_Request <= 1'b0;
      Out_Strobe   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (Run || Step) begin
            state_reg  <= S_FETCH;
            IP_Request <= 1'b1;
            blank_reg  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (blank_reg) begin
            blank_reg <= 1'b0;
          end else if (IP_Ready) begin
            CurInsn    <= Insn;
            IP_Request <= 1'b0;
            state_reg  <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (CurInsn)
            OP_INC, OP_DEC: begin
              Data_Request <= 1'b1;
              Data_Dec     <= (CurInsn == OP_DEC);
              Data_Set     <= 1'b0;
              blank_reg    <= 1'b1;
              state_reg    <= S_EXEC_WAIT;
            end
            OP_RGT, OP_LFT: begin
              AP_Request <= 1'b1;
              AP_Dec     <= (CurInsn == OP_LFT);
              blank_reg  <= 1'b1;
              state_reg  <= S_EXEC_WAIT;
            end
            OP_IN: begin
              In_Request <= 1'b1;
              state_reg  <= S_IN_WAIT;
            end
            OP_HALT: begin
              state_reg <= S_HALTED;
            end
            default: begin
              // '.', brackets and NOP-class codes retire straight from decode.
              Out_Strobe <= (CurInsn == OP_OUT);
              InsnCount  <= count_next;
              state_reg  <= retire_next;
              IP_Request <= Run;
              blank_reg  <= 1'b1;
            end
          endcase
        end
        S_EXEC_WAIT: begin
          if (blank_reg) begin
            blank_reg <= 1'b0;
          end else if (AP_Ready && Data_Ready) begin
            InsnCount  <= count_next;
            state_reg  <= retire_next;
            IP_Request <= Run;
            blank_reg  <= 1'b1;
          end
        end
        S_IN_WAIT: begin
          if (In_Valid) begin
            In_Request   <= 1'b0;
            Data_Request <= 1'b1;
            Data_Dec     <= 1'b0;
            Data_Set     <= 1'b1;
            blank_reg    <= 1'b1;
            state_reg    <= S_EXEC_WAIT;
          end
        end
        S_HALTED: begin
          state_reg <= S_HALTED;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_insn_sequencer.sv
// Directed bench for insn_sequencer: handshake models for the IP line,
// AP/Data counters and input port, with a scoreboard of request pulses.
module tb_insn_sequencer;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Run, Step;
  logic        IP_Request, IP_Ready;
  logic [3:0]  Insn;
  logic        dataIsZeroed;
  logic        AP_Request, AP_Dec, AP_Ready;
  logic        Data_Request, Data_Dec, Data_Set, Data_Ready, Data_Zero;
  logic        Out_Strobe, In_Request, In_Valid;
  logic [3:0]  CurInsn;
  logic        Busy, Halted;
  logic [15:0] InsnCount;

  logic        Run2;
  logic        ip_req2, dz2, ap_req2, ap_dec2, d_req2, d_dec2, d_set2, out2, in_req2;
  logic [3:0]  insn2, cur2;
  logic        busy2, halted2;
  logic [1:0]  count2;
  int          fetch2 = 0;

  always #5 Clk = ~Clk;

  insn_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Step(Step),
    .IP_Request(IP_Request), .IP_Ready(IP_Ready), .Insn(Insn),
    .dataIsZeroed(dataIsZeroed),
    .AP_Request(AP_Request), .AP_Dec(AP_Dec), .AP_Ready(AP_Ready),
    .Data_Request(Data_Request), .Data_Dec(Data_Dec), .Data_Set(Data_Set),
    .Data_Ready(Data_Ready), .Data_Zero(Data_Zero),
    .Out_Strobe(Out_Strobe), .In_Request(In_Request), .In_Valid(In_Valid),
    .CurInsn(CurInsn), .Busy(Busy), .Halted(Halted), .InsnCount(InsnCount)
  );

  // Narrow-counter instance: always-ready peers, five NOPs then HALT.
  insn_sequencer #(.INSN_WIDTH(4), .COUNT_WIDTH(2)) dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .Run(Run2), .Step(1'b0),
    .IP_Request(ip_req2), .IP_Ready(1'b1), .Insn(insn2),
    .dataIsZeroed(dz2),
    .AP_Request(ap_req2), .AP_Dec(ap_dec2), .AP_Ready(1'b1),
    .Data_Request(d_req2), .Data_Dec(d_dec2), .Data_Set(d_set2),
    .Data_Ready(1'b1), .Data_Zero(1'b0),
    .Out_Strobe(out2), .In_Request(in_req2), .In_Valid(1'b0),
    .CurInsn(cur2), .Busy(busy2), .Halted(halted2), .InsnCount(count2)
  );

  assign insn2 = (fetch2 < 5) ? 4'd0 : 4'd15;
  always @(negedge ip_req2) if (Run2) fetch2++;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] prog_q[$];
  logic [3:0] exp_q[$];
  int data_lat = 3;
  int in_delay = 10;
  int ip_cnt = 0, dat_cnt = 0, ap_cnt = 0, in_cnt = 0;
  int in_hi = 0, ip_hi = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Peer models, evaluated 1 time unit after each active edge.
  initial begin
    IP_Ready = 1'b1; AP_Ready = 1'b1; Data_Ready = 1'b1; In_Valid = 1'b0; Insn = 4'd0;
    forever begin
      @(posedge Clk); #1;
      if (!Rst_n) begin
        IP_Ready = 1'b1; AP_Ready = 1'b1; Data_Ready = 1'b1; In_Valid = 1'b0;
        ip_cnt = 0; dat_cnt = 0; ap_cnt = 0; in_cnt = 0;
      end else begin
        if (IP_Request) begin
          if (ip_cnt == 0) IP_Ready = 1'b0;
          ip_cnt++;
          if (ip_cnt == 3) begin
            Insn = (prog_q.size() > 0) ? prog_q.pop_front() : 4'd15;
            IP_Ready = 1'b1;
          end
        end else begin
          ip_cnt = 0;
          IP_Ready = 1'b1;
        end
        if (Data_Request) begin
          Data_Ready = 1'b0; dat_cnt = data_lat;
        end else if (dat_cnt > 0) begin
          dat_cnt--;
          if (dat_cnt == 0) Data_Ready = 1'b1;
        end
        if (AP_Request) begin
          AP_Ready = 1'b0; ap_cnt = 3;
          Data_Ready = 1'b0; dat_cnt = 4;
        end else if (ap_cnt > 0) begin
          ap_cnt--;
          if (ap_cnt == 0) AP_Ready = 1'b1;
        end
        if (In_Request) begin
          in_cnt++;
          if (in_cnt == in_delay) In_Valid = 1'b1;
        end else begin
          in_cnt = 0;
          In_Valid = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every pulse cycle pops one expected event {kind,dec,set}.
  task automatic sb_event(input logic [3:0] obs);
    if (exp_q.size() == 0) check("unexpected_pulse", {28'd0, obs}, 32'd0);
    else check("pulse", {28'd0, obs}, {28'd0, exp_q.pop_front()});
  endtask

  initial begin
    forever begin
      @(posedge Clk); #1;
      if (Data_Request) sb_event({2'd1, Data_Dec, Data_Set});
      if (AP_Request)   sb_event({2'd2, AP_Dec, 1'b0});
      if (Out_Strobe)   sb_event({2'd3, 2'b00});
      if (In_Request)   in_hi++;
      if (IP_Request)   ip_hi++;
    end
  end

  task automatic pulse_step();
    @(posedge Clk); #1 Step = 1'b1;
    @(posedge Clk); #1 Step = 1'b0;
  endtask

  task automatic wait_for(input int which, input int budget, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge Clk); #1;
      case (which)
        0: hit = !Busy;
        1: hit = Halted;
        2: hit = Data_Request;
        default: hit = halted2;
      endcase
    end
    check({"bound_", tag}, {31'd0, hit}, 32'd1);
  endtask

  function automatic logic [29:0] out_vec();
    return {IP_Request, AP_Request, AP_Dec, Data_Request, Data_Dec, Data_Set,
            Out_Strobe, In_Request, CurInsn, Busy, Halted, InsnCount};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0; Run = 1'b0; Step = 1'b0; Data_Zero = 1'b0; Run2 = 1'b0;
    repeat (3) @(posedge Clk);
    #1 check("reset_outputs", {2'd0, out_vec()}, 32'd0);
    Rst_n = 1'b1;

    // Single step of '+'
    prog_q.push_back(4'd1); exp_q.push_back({2'd1, 1'b0, 1'b0});
    pulse_step();
    wait_for(0, 50, "step_inc");
    check("step_count", {16'd0, InsnCount}, 32'd1);
    check("step_curinsn", {28'd0, CurInsn}, 32'd1);
    check("step_busy", {31'd0, Busy}, 32'd0);
    $display("txn step '+': count=%0d", InsnCount);

    // ',' with delayed input byte
    in_hi = 0;
    prog_q.push_back(4'd8); exp_q.push_back({2'd1, 1'b0, 1'b1});
    pulse_step();
    wait_for(0, 80, "in");
    check("in_request_cycles", in_hi, 32'd10);
    check("in_count", {16'd0, InsnCount}, 32'd2);
    $display("txn ',': in_request cycles=%0d count=%0d", in_hi, InsnCount);

    // '.'
    prog_q.push_back(4'd7); exp_q.push_back({2'd3, 2'b00});
    pulse_step();
    wait_for(0, 50, "out");
    check("out_count", {16'd0, InsnCount}, 32'd3);
    $display("txn '.': count=%0d", InsnCount);

    // '[' with zero cell, then check feedback during next fetch
    Data_Zero = 1'b1;
    prog_q.push_back(4'd5); prog_q.push_back(4'd0);
    pulse_step();
    wait_for(0, 50, "bracket");
    pulse_step();
    check("next_ip_request", {31'd0, IP_Request}, 32'd1);
    check("data_is_zeroed", {31'd0, dataIsZeroed}, 32'd1);
    wait_for(0, 50, "nop");
    check("bracket_count", {16'd0, InsnCount}, 32'd5);
    Data_Zero = 1'b0;
    $display("txn '[' + NOP: count=%0d", InsnCount);

    // Asynchronous reset during EXEC_WAIT
    data_lat = 8;
    prog_q.push_back(4'd2); exp_q.push_back({2'd1, 1'b1, 1'b0});
    pulse_step();
    wait_for(2, 50, "dec_req");
    #3 Rst_n = 1'b0;
    #1 check("async_reset_outputs", {2'd0, out_vec()}, 32'd0);
    @(posedge Clk); #1 Rst_n = 1'b1;
    data_lat = 3;
    prog_q.push_back(4'd1); exp_q.push_back({2'd1, 1'b0, 1'b0});
    pulse_step();
    wait_for(0, 50, "resume");
    check("resume_count", {16'd0, InsnCount}, 32'd1);
    $display("txn reset mid-exec then '+': count=%0d", InsnCount);

    // Free run '>' '<' HALT
    #2 Rst_n = 1'b0;
    @(posedge Clk); #1 Rst_n = 1'b1;
    prog_q.push_back(4'd3); prog_q.push_back(4'd4); prog_q.push_back(4'd15);
    exp_q.push_back({2'd2, 1'b0, 1'b0}); exp_q.push_back({2'd2, 1'b1, 1'b0});
    Run = 1'b1;
    wait_for(1, 200, "halt");
    Run = 1'b0;
    check("halted", {31'd0, Halted}, 32'd1);
    check("halt_count", {16'd0, InsnCount}, 32'd2);
    check("halt_curinsn", {28'd0, CurInsn}, 32'd15);
    ip_hi = 0;
    pulse_step();
    repeat (5) @(posedge Clk);
    #1 check("halt_step_no_fetch", ip_hi, 32'd0);
    check("halt_sticky", {31'd0, Halted}, 32'd1);
    $display("txn run '>' '<' HALT: count=%0d halted=%0d", InsnCount, Halted);

    // Saturation on the 2-bit counter
    @(posedge Clk); #1 Run2 = 1'b1;
    wait_for(3, 200, "sat_halt");
    Run2 = 1'b0;
    check("sat_count", {30'd0, count2}, 32'd3);
    check("sat_curinsn", {28'd0, cur2}, 32'd15);
    $display("txn 5xNOP HALT width2: count=%0d", count2);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
